// File: rtl/ccpu_pkg.sv
// rtl/ccpu_pkg.sv - shared constants for the pointer bank slice
// Contents: default data width and pointer count, address-source encodings.
package ccpu_pkg;
    localparam int   DW_DEFAULT    = 8;
    localparam int   N_PTR_DEFAULT = 4;

    // Address-source select values carried on addr_dp.
    localparam logic ADDR_IP = 1'b0;
    localparam logic ADDR_DP = 1'b1;
endpackage

// File: rtl/pointer_bank_if.sv
// rtl/pointer_bank_if.sv - control/bus bundle for the pointer bank
// master: drives di, wsel, we_lo, we_hi, dsel, cnt, dp_inc, swap, addr_dp,
//         oe_addr, oe_dl, oe_dh; receives addr_out, data_out, wrap.
// slave:  the pointer bank side of the same signals.
interface pointer_bank_if #(
    parameter int DW    = ccpu_pkg::DW_DEFAULT,
    parameter int N_PTR = ccpu_pkg::N_PTR_DEFAULT
);
    localparam int AW = 2 * DW;
    localparam int SW = $clog2(N_PTR);

    logic [DW-1:0] di;
    logic [SW-1:0] wsel;
    logic          we_lo;
    logic          we_hi;
    logic [SW-1:0] dsel;
    logic          cnt;
    logic          dp_inc;
    logic          swap;
    logic          addr_dp;
    logic          oe_addr;
    logic          oe_dl;
    logic          oe_dh;
    wire  [AW-1:0] addr_out;
    wire  [DW-1:0] data_out;
    logic          wrap;

    modport master (
        output di, wsel, we_lo, we_hi, dsel, cnt, dp_inc, swap,
               addr_dp, oe_addr, oe_dl, oe_dh,
        input  addr_out, data_out, wrap
    );

    modport slave (
        input  di, wsel, we_lo, we_hi, dsel, cnt, dp_inc, swap,
               addr_dp, oe_addr, oe_dl, oe_dh,
        output addr_out, data_out, wrap
    );
endinterface

// File: rtl/ptr_cell.sv
// rtl/ptr_cell.sv - one 2*DW-bit pointer with byte load and increment
// Ports: nclk/rst clock and async active-low reset; di byte source;
//        we_lo/we_hi byte loads; inc +1; q current value;
//        roll high when this cycle's increment wraps all-ones to zero.
module ptr_cell
    import ccpu_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic            nclk,
    input  logic            rst,
    input  logic [DW-1:0]   di,
    input  logic            we_lo,
    input  logic            we_hi,
    input  logic            inc,
    output logic [2*DW-1:0] q,
    output logic            roll
);
    localparam int AW = 2 * DW;

    logic [AW-1:0] val_q;
    logic [AW-1:0] val_d;

    // A byte load suppresses the increment for the whole pointer.
    always_comb begin
        val_d = val_q;
        roll  = 1'b0;
        if (we_lo || we_hi) begin
            if (we_lo) val_d[DW-1:0]  = di;
            if (we_hi) val_d[AW-1:DW] = di;
        end else if (inc) begin
            val_d = val_q + AW'(1);
            roll  = &val_q;
        end
    end

    always_ff @(posedge nclk or negedge rst) begin
        if (!rst) val_q <= '0;
        else      val_q <= val_d;
    end

    assign q = val_q;
endmodule

// File: rtl/pointer_bank.sv
// rtl/pointer_bank.sv - N_PTR address pointers behind a logical-to-physical map
// Ports: nclk clock; rst async active-low reset; bus (slave) carries the byte
//        load, increment, swap and select controls plus the tri-state
//        addr_out / data_out buses and the registered wrap flag.
module pointer_bank
    import ccpu_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int N_PTR = N_PTR_DEFAULT
) (
    input  logic          nclk,
    input  logic          rst,
    pointer_bank_if.slave bus
);
    localparam int AW = 2 * DW;
    localparam int SW = $clog2(N_PTR);

    logic [SW-1:0]    map_q [N_PTR];
    logic [SW-1:0]    map_d [N_PTR];
    logic             wrap_q;
    logic             wrap_d;
    logic [AW-1:0]    ptr   [N_PTR];
    logic [N_PTR-1:0] roll;

    // Physical targets, all resolved through the map as it stands before the edge.
    logic [SW-1:0] phys_w;
    logic [SW-1:0] phys_ip;
    logic [SW-1:0] phys_dp;

    assign phys_w  = map_q[bus.wsel];
    assign phys_ip = map_q[0];
    assign phys_dp = map_q[bus.dsel];

    for (genvar p = 0; p < N_PTR; p++) begin : g_ptr
        logic sel_w;
        logic sel_inc;

        assign sel_w   = (phys_w == SW'(p));
        // cnt and dp_inc on the same physical pointer still add only one.
        assign sel_inc = (bus.cnt    && (phys_ip == SW'(p))) ||
                         (bus.dp_inc && (phys_dp == SW'(p)));

        ptr_cell #(.DW(DW)) u_cell (
            .nclk  (nclk),
            .rst   (rst),
            .di    (bus.di),
            .we_lo (bus.we_lo && sel_w),
            .we_hi (bus.we_hi && sel_w),
            .inc   (sel_inc),
            .q     (ptr[p]),
            .roll  (roll[p])
        );
    end

    // Transposition of map[0] and map[dsel]; dsel = 0 degenerates to a no-op.
    always_comb begin
        map_d = map_q;
        if (bus.swap) begin
            map_d[0]        = map_q[bus.dsel];
            map_d[bus.dsel] = map_q[0];
        end
        wrap_d = |roll;
    end

    always_ff @(posedge nclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_PTR; i++) map_q[i] <= SW'(i);
            wrap_q <= 1'b0;
        end else begin
            map_q  <= map_d;
            wrap_q <= wrap_d;
        end
    end

    logic [AW-1:0] ip_val;
    logic [AW-1:0] dp_val;
    logic [AW-1:0] addr_val;
    logic [DW-1:0] byte_val;

    assign ip_val   = ptr[phys_ip];
    assign dp_val   = ptr[phys_dp];
    assign addr_val = (bus.addr_dp == ADDR_DP) ? dp_val : ip_val;
    // Low byte takes priority if both byte enables are ever high.
    assign byte_val = bus.oe_dl ? dp_val[DW-1:0] : dp_val[AW-1:DW];

    assign bus.addr_out = bus.oe_addr ? addr_val : {AW{1'bz}};
    assign bus.data_out = (bus.oe_dl || bus.oe_dh) ? byte_val : {DW{1'bz}};
    assign bus.wrap     = wrap_q;

    a_oe_exclusive: assert property (@(posedge nclk) disable iff (!rst)
                                     !(bus.oe_dl && bus.oe_dh));
endmodule

// File: doc/pointer_bank.md
Name: pointer_bank

Overview:
- Parametrised successor to the two-pointer IP/DP pair.
- Holds N_PTR physical address pointers of AW = 2*DW bits, with byte-wise load from the internal data bus.
- Logical pointer 0 is always the instruction pointer (IP); logical 1..N_PTR-1 are data pointers. A logical-to-physical map register allows swapping IP with any data pointer.
- Adds DP post-increment and a registered wrap indication; drives the tri-state address bus and the ALU-B byte bus.

Parameters:
- DW, 8, data/byte width; AW = 2*DW is derived (localparam).
- N_PTR, 4, number of physical pointers; must be a power of 2, minimum 2.
- SW, $clog2(N_PTR), width of logical pointer selectors (localparam).

Ports:
- nclk  in  1  clock; all state updates on posedge nclk.
- rst  in  1  reset, asynchronous, active-low.
- di  in  DW  internal data bus, source of byte loads.
- wsel  in  SW  logical pointer targeted by we_lo/we_hi.
- we_lo  in  1  load di into bits [DW-1:0] of logical pointer wsel.
- we_hi  in  1  load di into bits [AW-1:DW] of logical pointer wsel.
- dsel  in  SW  logical data pointer used by dp_inc, swap, addr_dp and the data outputs.
- cnt  in  1  increment IP by 1.
- dp_inc  in  1  increment logical pointer dsel by 1.
- swap  in  1  exchange the map entries of logical 0 and logical dsel.
- addr_dp  in  1  address source select: 0 = IP, 1 = logical dsel.
- oe_addr  in  1  active-high; addr_out is high-Z when 0.
- oe_dl  in  1  active-high; data_out = low byte of logical dsel.
- oe_dh  in  1  active-high; data_out = high byte of logical dsel.
- addr_out  out  AW  tri-state address bus.
- data_out  out  DW  tri-state ALU-B byte bus.
- wrap  out  1  registered; high for one cycle after any increment that rolled over from all-ones to 0.

Behaviour:
- Reset (rst=0, async): all pointers = 0, map[i] = i (identity), wrap = 0. Outputs follow the oe inputs even during reset; an enabled bus shows 0.
- Outputs are combinational from the current registers and map. Updates take effect on the next posedge nclk; load-to-visible latency is 1 edge.
- All same-cycle operations use the pre-edge map. swap and any write/increment in the same cycle act on physical pointers selected by the old map; the new map applies from the next cycle.
- Write vs increment on the same logical pointer: any we_lo/we_hi wins. The untouched byte keeps its old value and no increment occurs that cycle.
- we_lo and we_hi together: both bytes load di. This is a legal but unusual case.
- cnt and dp_inc with dsel = 0: IP is incremented by 1, not 2.
- dsel = 0 makes swap a no-op. dp_inc then aliases cnt.
- Increment arithmetic is modulo 2^AW. 0xFFFF+1 = 0x0000 and sets wrap on the next edge. wrap clears on the following edge unless another rollover occurs.
- oe_dl and oe_dh both high is illegal. Simulation asserts; the RTL drives the low byte.
- State machine (map register): each swap with dsel = k performs one transposition of map[0] and map[k]. Map states are the permutations reachable by transpositions, starting from identity.
- Reset mid-operation: async clear overrides everything, including pending writes and swaps.

Decomposition:
- Shared package ccpu_pkg holds DW_DEFAULT = 8, N_PTR_DEFAULT = 4, and the address-select encodings ADDR_IP = 0, ADDR_DP = 1.
- One natural sub-module, ptr_cell: a single AW-bit pointer with byte load, increment, and a rollover output. pointer_bank instantiates N_PTR of these and holds the map register, the mux and the tri-state drivers.

Test Plan:
- Reset, then oe_addr=1, addr_dp=0 -> addr_out = 0x0000. With oe_addr=0 -> addr_out = Z. map is identity.
- wsel=1, di=0x34 with we_lo; then di=0x12 with we_hi; then addr_dp=1, dsel=1 -> addr_out = 0x1234; oe_dh=1 -> data_out = 0x12.
- Load IP = 0xFFFF, pulse cnt -> addr_out = 0x0000 and wrap = 1 for exactly one cycle.
- Pointer 2 = 0xABCD, IP = 0x0010; swap with dsel=2 -> IP reads 0xABCD and logical 2 reads 0x0010. A second swap restores both.
- Same cycle: swap (dsel=1), cnt, and we_lo to wsel=0 with di=0x55 -> the pre-swap IP physical pointer gets low byte 0x55 with no increment, and is now logical 1.
- Assert rst low mid-cycle while dp_inc=1 -> all pointers 0 and map identity immediately, with no increment applied.
